sw_array_feeder: RTL

Upstream sequencer for the Smith-Waterman systolic PE array. It collects a query of exactly NUM_PE bases from a stall-tolerant stream and broadcasts them into the array with a single travelling store pulse. It then drives the reference stream into PE 0 with a gap-free `init` window, and drains the array before reporting completion. The array cannot stall, so this block absorbs all upstream flow control and turns reference underflow into a clean abort.

---
 rtl/sw_pkg.sv | 31 +++
 rtl/sw_query_buffer.sv | 28 ++
 rtl/sw_array_feeder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared encodings for the Smith-Waterman array feeder: base codes, FSM states, status codes.
package sw_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_C = 2'b01,
    BASE_G = 2'b10,
    BASE_T = 2'b11
  } base_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER,
    ST_LOAD,
    ST_ARM,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    STAT_OK        = 2'b00,
    STAT_UNDERFLOW = 2'b01,
    STAT_OVERFLOW  = 2'b10
  } status_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sw_query_buffer.sv
// NUM_PE x 2-bit query store: shifts bases in at the tail while gathering and
// rotates them past the head while loading; head_d is the head after this edge.
module sw_query_buffer #(
  parameter int NUM_PE = 32
) (
  input  logic       clk,
  input  logic       shift_en,
  input  logic       rot_en,
  input  logic [1:0] base_in,
  output logic [1:0] head_d
);

  logic [NUM_PE-1:0][1:0] qbuf_q, qbuf_d;

  always_comb begin
    qbuf_d = qbuf_q;
    if (shift_en || rot_en) begin
      for (int i = 0; i < NUM_PE - 1; i++) qbuf_d[i] = qbuf_q[i+1];
      qbuf_d[NUM_PE-1] = shift_en ? base_in : qbuf_q[0];
    end
  end

  // Contents are rewritten by every gather, so no reset is needed.
  always_ff @(posedge clk) qbuf_q <= qbuf_d;

  assign head_d = qbuf_d[0];

endmodule

// File: rtl/sw_array_feeder.sv
// Sequencer feeding a non-stallable Smith-Waterman PE array: gathers the query,
// broadcasts it with one travelling store pulse, streams the reference, drains.
module sw_array_feeder
  import sw_pkg::*;
#(
  parameter int NUM_PE = 32,
  parameter int RLEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [1:0]        q_base,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [1:0]        r_base,
  input  logic              r_last,
  output logic [1:0]        S_out,
  output logic              store_S_out,
  output logic [1:0]        T_out,
  output logic              init_out,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [RLEN_W-1:0] ref_count
);

  localparam int QW = cnt_w(NUM_PE);
  localparam int DW = cnt_w(NUM_PE + 1);
  localparam logic [QW-1:0]     Q_LAST   = QW'(NUM_PE - 1);
  localparam logic [DW-1:0]     D_LAST   = DW'(NUM_PE);
  localparam logic [RLEN_W-1:0] R_PENULT = ~RLEN_W'(1);

  state_e            state_q, state_d;
  status_e           status_q, status_d;
  logic [QW-1:0]     q_cnt_q, q_cnt_d;
  logic [QW-1:0]     load_cnt_q, load_cnt_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [RLEN_W-1:0] ref_count_q, ref_count_d;
  logic              q_ready_q, q_ready_d;
  logic              r_ready_q, r_ready_d;
  logic              store_q, store_d;
  logic              init_q, init_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        s_out_q, s_out_d;
  logic [1:0]        t_out_q, t_out_d;
  logic              shift_en, rot_en, q_acc, r_acc;
  logic [1:0]        head_d;

  sw_query_buffer #(.NUM_PE(NUM_PE)) u_qbuf (
    .clk      (clk),
    .shift_en (shift_en),
    .rot_en   (rot_en),
    .base_in  (q_base),
    .head_d   (head_d)
  );

  assign q_acc = q_valid && q_ready_q;
  assign r_acc = r_valid && r_ready_q;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    q_cnt_d     = q_cnt_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    ref_count_d = ref_count_q;
    store_d     = 1'b0;
    init_d      = 1'b0;
    done_d      = 1'b0;
    t_out_d     = BASE_A;
    shift_en    = 1'b0;
    rot_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        q_cnt_d     = '0;
        ref_count_d = '0;
        status_d    = STAT_OK;
        if (start) state_d = ST_GATHER;
      end
      ST_GATHER: begin
        if (q_acc) begin
          shift_en = 1'b1;
          if (q_cnt_q == Q_LAST) begin
            q_cnt_d    = '0;
            load_cnt_d = '0;
            store_d    = 1'b1;
            state_d    = ST_LOAD;
          end else begin
            q_cnt_d = q_cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD: begin
        rot_en = 1'b1;
        if (load_cnt_q == Q_LAST) state_d = ST_ARM;
        else                      load_cnt_d = load_cnt_q + 1'b1;
      end
      ST_ARM: begin
        if (r_valid) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (r_acc) begin
          t_out_d     = r_base;
          init_d      = 1'b1;
          ref_count_d = ref_count_q + 1'b1;
          if (r_last) begin
            status_d    = STAT_OK;
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end else if (ref_count_q == R_PENULT) begin
            status_d    = STAT_OVERFLOW;
            drain_cnt_d = '0;
            state_d     = ST_DRAIN;
          end
        end else begin
          // The starved cycle already counts as the first drain cycle.
          status_d    = STAT_UNDERFLOW;
          drain_cnt_d = DW'(1);
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == D_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    q_ready_d = (state_d == ST_GATHER);
    r_ready_d = (state_d == ST_STREAM);
    busy_d    = (state_d != ST_IDLE);
    s_out_d   = (state_d == ST_LOAD) ? head_d : s_out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      status_q    <= STAT_OK;
      q_cnt_q     <= '0;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
      ref_count_q <= '0;
      q_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      store_q     <= 1'b0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s_out_q     <= BASE_A;
      t_out_q     <= BASE_A;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      q_cnt_q     <= q_cnt_d;
      load_cnt_q  <= load_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ref_count_q <= ref_count_d;
      q_ready_q   <= q_ready_d;
      r_ready_q   <= r_ready_d;
      store_q     <= store_d;
      init_q      <= init_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s_out_q     <= s_out_d;
      t_out_q     <= t_out_d;
    end
  end

  assign q_ready     = q_ready_q;
  assign r_ready     = r_ready_q;
  assign store_S_out = store_q;
  assign init_out    = init_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign S_out       = s_out_q;
  assign T_out       = t_out_q;
  assign status      = status_q;
  assign ref_count   = ref_count_q;

endmodule
